mux_scan_serializer: RTL and testbench

Parallel-to-serial controller for the 4:1 multiplexer stage. It accepts a 4-bit word over a valid/ready handshake and holds it on the mux data inputs `x`. It then steps the mux select `s` through the four positions and presents the selected bit, returned on `y_in`, as a handshaked serial stream. The block sits directly upstream of the mux, which it drives through `x` and `s`. It also sits directly downstream of it, because it consumes the mux output `y`.

---
 rtl/mux_scan_serializer.sv | 116 +++++++++++
 tb/tb_mux_scan_serializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial controller for a 4:1 mux: holds a word on x, steps the
// select s and forwards the returned mux output as a handshaked bit stream.
module mux_scan_serializer #(
  parameter bit LSB_FIRST = 1'b1,
  parameter int HOLD      = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic [3:0] i_din,
  input  logic       i_din_valid,
  output logic       o_din_ready,
  output logic [3:0] o_x,
  output logic [1:0] o_s,
  input  logic       i_y_in,
  output logic       o_sout,
  output logic       o_sout_valid,
  input  logic       i_sout_ready,
  output logic       o_sout_last,
  output logic       o_busy
);

  localparam logic [1:0] START_IDX = LSB_FIRST ? 2'd0 : 2'd3;
  localparam logic [1:0] FINAL_IDX = LSB_FIRST ? 2'd3 : 2'd0;
  // Adding 3 modulo 4 steps the select downward for MSB-first order.
  localparam logic [1:0] STEP      = LSB_FIRST ? 2'd1 : 2'd3;
  localparam logic [3:0] HOLD_MAX  = 4'(HOLD - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_x;
  logic [1:0] r_s;
  logic [3:0] r_cnt;

  logic w_final;
  logic w_hold_done;
  logic w_xfer;
  logic w_load;

  assign w_final     = (r_s == FINAL_IDX);
  assign w_hold_done = (r_cnt == HOLD_MAX);
  assign w_xfer      = o_sout_valid & i_sout_ready & ~i_clr;
  assign w_load      = i_din_valid & o_din_ready & ~i_clr;

  assign o_x    = r_x;
  assign o_s    = r_s;
  assign o_sout = i_y_in;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // clr wins over both a reload and a final-bit transfer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_load) w_next = SEND;
      end
      SEND: begin
        if (i_clr)                   w_next = IDLE;
        else if (w_load)             w_next = SEND;
        else if (w_xfer && w_final)  w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // din_ready in SEND opens only on the final-bit transfer for back-to-back words.
  always_comb begin
    o_din_ready  = 1'b0;
    o_sout_valid = 1'b0;
    o_sout_last  = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        o_din_ready = 1'b1;
      end
      SEND: begin
        o_busy       = 1'b1;
        o_sout_valid = w_hold_done;
        o_sout_last  = w_hold_done & w_final;
        o_din_ready  = w_hold_done & w_final & i_sout_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x   <= 4'b0000;
      r_s   <= START_IDX;
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (w_load) begin
      r_x   <= i_din;
      r_s   <= START_IDX;
      r_cnt <= 4'd0;
    end else if (w_xfer) begin
      if (!w_final) begin
        r_s   <= r_s + STEP;
        r_cnt <= 4'd0;
      end
    end else if (r_state == SEND && !w_hold_done) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench: three serializer instances (LSB/HOLD=1, MSB/HOLD=1,
// LSB/HOLD=3), each closing the loop through a behavioural 4:1 mux.
module tb_mux_scan_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       clr0, dv0, sr0, rdy0, so0, sv0, sl0, busy0, y0;
  logic [3:0] din0, x0;
  logic [1:0] s0;
  logic       clr1, dv1, sr1, rdy1, so1, sv1, sl1, busy1, y1;
  logic [3:0] din1, x1;
  logic [1:0] s1;
  logic       clr2, dv2, sr2, rdy2, so2, sv2, sl2, busy2, y2;
  logic [3:0] din2, x2;
  logic [1:0] s2;

  assign y0 = x0[s0];
  assign y1 = x1[s1];
  assign y2 = x2[s2];

  logic [7:0] st0, st1, st2;
  assign st0 = {1'b0, s0, sv0, so0, sl0, rdy0, busy0};
  assign st1 = {1'b0, s1, sv1, so1, sl1, rdy1, busy1};
  assign st2 = {1'b0, s2, sv2, so2, sl2, rdy2, busy2};

  mux_scan_serializer #(.LSB_FIRST(1'b1), .HOLD(1)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr0), .i_din(din0), .i_din_valid(dv0),
    .o_din_ready(rdy0), .o_x(x0), .o_s(s0), .i_y_in(y0), .o_sout(so0),
    .o_sout_valid(sv0), .i_sout_ready(sr0), .o_sout_last(sl0), .o_busy(busy0));

  mux_scan_serializer #(.LSB_FIRST(1'b0), .HOLD(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr1), .i_din(din1), .i_din_valid(dv1),
    .o_din_ready(rdy1), .o_x(x1), .o_s(s1), .i_y_in(y1), .o_sout(so1),
    .o_sout_valid(sv1), .i_sout_ready(sr1), .o_sout_last(sl1), .o_busy(busy1));

  mux_scan_serializer #(.LSB_FIRST(1'b1), .HOLD(3)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr2), .i_din(din2), .i_din_valid(dv2),
    .o_din_ready(rdy2), .o_x(x2), .o_s(s2), .i_y_in(y2), .o_sout(so2),
    .o_sout_valid(sv2), .i_sout_ready(sr2), .o_sout_last(sl2), .o_busy(busy2));

  // Expected status vector: {0, s, sout_valid, sout, sout_last, din_ready, busy}
  function automatic logic [7:0] st(input int s, input logic sv, input logic so,
                                    input logic sl, input logic rdy, input logic busy);
    logic [1:0] s2b;
    s2b = 2'(s);
    return {1'b0, s2b, sv, so, sl, rdy, busy};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] lsb_bits, msb_bits, flush2_bits;
    logic [7:0] b2b_bits;
    lsb_bits    = 4'b1011;  // bit k transmitted at step k
    msb_bits    = 4'b1101;  // 1011 sent MSB first: 1,0,1,1
    b2b_bits    = 8'b01011010;
    flush2_bits = 4'b0011;

    {clr0, dv0, din0} = '0; sr0 = 1'b1;
    {clr1, dv1, din1} = '0; sr1 = 1'b1;
    {clr2, dv2, din2} = '0; sr2 = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk("reset u0", st0, st(0, 0, 0, 0, 1, 0));
    chk("reset u0 x", {4'h0, x0}, 8'h00);
    chk("reset u1", st1, st(3, 0, 0, 0, 1, 0));
    chk("reset u2", st2, st(0, 0, 0, 0, 1, 0));
    @(negedge clk); rst_n = 1'b1;

    // LSB-first serialization of 1011
    @(negedge clk); din0 = 4'b1011; dv0 = 1'b1; #1;
    chk("lsb idle", st0, st(0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); dv0 = 1'b0; #1;
      chk($sformatf("lsb bit%0d", k), st0, st(k, 1, lsb_bits[k], k == 3, k == 3, 1));
    end
    @(negedge clk); #1;
    chk("lsb done", {6'd0, sv0, busy0}, 8'h00);

    // MSB-first serialization of 1011
    @(negedge clk); din1 = 4'b1011; dv1 = 1'b1; #1;
    chk("msb idle", st1, st(3, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); dv1 = 1'b0; #1;
      chk($sformatf("msb bit%0d", k), st1, st(3 - k, 1, msb_bits[k], k == 3, k == 3, 1));
    end
    @(negedge clk); #1;
    chk("msb done", {6'd0, sv1, busy1}, 8'h00);

    // Backpressure with HOLD=3 on word 0101
    @(negedge clk); din2 = 4'b0101; dv2 = 1'b1; #1;
    chk("bp idle rdy", {7'd0, rdy2}, 8'h01);
    @(negedge clk); dv2 = 1'b0; #1;
    chk("bp hold0", st2, st(0, 0, 1, 0, 0, 1));
    @(negedge clk); #1;
    chk("bp hold1", st2, st(0, 0, 1, 0, 0, 1));
    @(negedge clk); #1;
    chk("bp bit0", st2, st(0, 1, 1, 0, 0, 1));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk($sformatf("bp b1 hold%0d", k), st2, st(1, 0, 0, 0, 0, 1));
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); sr2 = 1'b0; #1;
      chk($sformatf("bp stall%0d", k), st2, st(1, 1, 0, 0, 0, 1));
      chk($sformatf("bp stall%0d x", k), {4'h0, x2}, 8'h05);
    end
    @(negedge clk); sr2 = 1'b1; #1;
    chk("bp release", st2, st(1, 1, 0, 0, 0, 1));
    @(negedge clk); #1;
    chk("bp once", st2, st(2, 0, 1, 0, 0, 1));
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("bp bit2", st2, st(2, 1, 1, 0, 0, 1));
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("bp bit3", st2, st(3, 1, 0, 1, 1, 1));
    @(negedge clk); #1;
    chk("bp done", {6'd0, sv2, busy2}, 8'h00);

    // Back-to-back words A then 5, HOLD=1
    @(negedge clk); din0 = 4'hA; dv0 = 1'b1; #1;
    chk("b2b idle rdy", {7'd0, rdy0}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) din0 = 4'h5;
      if (i == 7) dv0 = 1'b0;
      #1;
      chk($sformatf("b2b bit%0d", i), st0,
          st(i % 4, 1, b2b_bits[i], (i % 4) == 3, (i % 4) == 3, 1));
    end
    @(negedge clk); #1;
    chk("b2b done", {6'd0, sv0, busy0}, 8'h00);

    // Flush during bit 2, then a normal word
    @(negedge clk); din0 = 4'hF; dv0 = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); dv0 = 1'b0;
      if (k == 2) clr0 = 1'b1;
      #1;
      chk($sformatf("flush bit%0d", k), st0, st(k, 1, 1, 0, 0, 1));
    end
    @(negedge clk); clr0 = 1'b0; din0 = 4'b0011; dv0 = 1'b1; #1;
    chk("flush idle", {5'd0, sv0, sl0, busy0}, 8'h00);
    chk("flush x kept", {4'h0, x0}, 8'h0F);
    chk("flush rdy", {7'd0, rdy0}, 8'h01);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); dv0 = 1'b0; #1;
      chk($sformatf("post-flush bit%0d", k), st0,
          st(k, 1, flush2_bits[k], k == 3, k == 3, 1));
    end
    @(negedge clk); #1;
    chk("post-flush done", {6'd0, sv0, busy0}, 8'h00);

    // Asynchronous reset during bit 2 of word 0110
    @(negedge clk); din0 = 4'b0110; dv0 = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); dv0 = 1'b0; #1;
      chk($sformatf("mid bit%0d", k), st0, st(k, 1, (k != 0), 0, 0, 1));
    end
    #1 rst_n = 1'b0;
    #1;
    chk("async rst u0", st0, st(0, 0, 0, 0, 1, 0));
    chk("async rst x", {4'h0, x0}, 8'h00);
    chk("async rst u1", st1, st(3, 0, 0, 0, 1, 0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
